// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: FSM states, halt constants, opcodes, control bundle.
// Combinational helpers only; no latency, no flow control.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int         DRAIN_CYCLES_DEF = 3;
    localparam logic [4:0] REG_A7           = 5'd17;
    localparam int         HALT_CODE        = 10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;

    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic write_enable;
        logic pc_to_reg;
    } ctrl_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_ARITH || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use and ecall-operand hazard detection; purely combinational, zero latency.
// Ecall term is present only when ECALL_STALL_EN is defined.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic       id_is_ecall_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_write_enable_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_write_enable_i,
    output logic       load_use_o,
    output logic       ecall_hazard_o
);

    assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                        (((ex_rd_i == id_rs1_i) & use_rs1_i) |
                         ((ex_rd_i == id_rs2_i) & use_rs2_i));

`ifdef ECALL_STALL_EN
    // x17 still owned by an older writer in EX or MEM; WB is covered by the RF bypass.
    assign ecall_hazard_o = id_is_ecall_i &
                            ((ex_write_enable_i & (ex_rd_i == REG_A7)) |
                             (mem_write_enable_i & (mem_rd_i == REG_A7)));
`else
    logic unused_ecall_inputs;
    assign unused_ecall_inputs = &{1'b0, id_is_ecall_i, ex_write_enable_i, mem_rd_i, mem_write_enable_i};
    assign ecall_hazard_o      = 1'b0;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard bubbles and ecall halt-drain FSM (optional ECALL_STALL_EN).
// Latency 1 cycle ID->EX; stall holds PC and IF/ID while a bubble is loaded into EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = id_ex_stage_pkg::DRAIN_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            ctrl_mem_read,
    input  logic            ctrl_mem_to_reg,
    input  logic            ctrl_mem_write,
    input  logic            ctrl_alu_src,
    input  logic            ctrl_write_enable,
    input  logic            ctrl_pc_to_reg,
    input  logic            ctrl_is_ecall,
    input  logic [4:0]      mem_rd,
    input  logic            mem_write_enable,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_write_enable,
    output logic            ex_pc_to_reg,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic            is_halted
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]      funct_q, funct_d;

    logic [6:0] opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    ctrl_t      id_ctrl;
    logic       load_use, ecall_hazard, halt_issue;
    logic       unused_inst_bits;

    assign opcode  = id_inst[6:0];
    assign id_rs1  = ctrl_is_ecall ? REG_A7 : id_inst[19:15];
    assign id_rs2  = id_inst[24:20];
    assign id_rd   = id_inst[11:7];
    assign id_ctrl = '{mem_read: ctrl_mem_read, mem_to_reg: ctrl_mem_to_reg, mem_write: ctrl_mem_write,
                       alu_src: ctrl_alu_src, write_enable: ctrl_write_enable, pc_to_reg: ctrl_pc_to_reg};
    assign unused_inst_bits = &{1'b0, id_inst[31], id_inst[29:25]};

    id_ex_stage_hazard_detect u_hazard_detect (
        .id_rs1_i           (id_rs1),
        .id_rs2_i           (id_rs2),
        .use_rs1_i          (uses_rs1(opcode)),
        .use_rs2_i          (uses_rs2(opcode)),
        .id_is_ecall_i      (ctrl_is_ecall),
        .ex_valid_i         (valid_q),
        .ex_mem_read_i      (ctrl_q.mem_read),
        .ex_write_enable_i  (ctrl_q.write_enable),
        .ex_rd_i            (rd_q),
        .mem_rd_i           (mem_rd),
        .mem_write_enable_i (mem_write_enable),
        .load_use_o         (load_use),
        .ecall_hazard_o     (ecall_hazard)
    );

    assign stall      = id_valid & (load_use | ecall_hazard) & (state_q == ST_RUN);
    assign halt_issue = id_valid & ctrl_is_ecall & (id_rs1_data == XLEN'(HALT_CODE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        valid_d    = 1'b0;
        ctrl_d     = '0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        funct_d    = '0;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt_issue) begin
                        // The halting ecall itself becomes a bubble in EX.
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(DRAIN_CYCLES - 1);
                    end else begin
                        valid_d    = id_valid;
                        ctrl_d     = id_valid ? id_ctrl : '0;
                        pc_d       = id_pc;
                        rs1_data_d = id_rs1_data;
                        rs2_data_d = id_rs2_data;
                        imm_d      = id_imm;
                        rs1_d      = id_rs1;
                        rs2_d      = id_rs2;
                        rd_d       = id_rd;
                        funct_d    = {id_inst[30], id_inst[14:12]};
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halted_q   <= halted_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
        end
    end

    assign ex_valid        = valid_q;
    assign ex_mem_read     = ctrl_q.mem_read;
    assign ex_mem_to_reg   = ctrl_q.mem_to_reg;
    assign ex_mem_write    = ctrl_q.mem_write;
    assign ex_alu_src      = ctrl_q.alu_src;
    assign ex_write_enable = ctrl_q.write_enable;
    assign ex_pc_to_reg    = ctrl_q.pc_to_reg;
    assign ex_pc           = pc_q;
    assign ex_rs1_data     = rs1_data_q;
    assign ex_rs2_data     = rs2_data_q;
    assign ex_imm          = imm_q;
    assign ex_rs1          = rs1_q;
    assign ex_rs2          = rs2_q;
    assign ex_rd           = rd_q;
    assign ex_funct        = funct_q;
    assign is_halted       = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents queued at drive time, popped after the edge.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [6:0]      id_ctl;
    logic [4:0]      mem_rd = '0;
    logic            mem_write_enable = 1'b0;

    logic            stall, ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write;
    logic            ex_alu_src, ex_write_enable, ex_pc_to_reg, is_halted;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_funct;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .ctrl_mem_read(id_ctl[6]), .ctrl_mem_to_reg(id_ctl[5]), .ctrl_mem_write(id_ctl[4]),
        .ctrl_alu_src(id_ctl[3]), .ctrl_write_enable(id_ctl[2]), .ctrl_pc_to_reg(id_ctl[1]),
        .ctrl_is_ecall(id_ctl[0]), .mem_rd(mem_rd), .mem_write_enable(mem_write_enable),
        .stall(stall), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_write_enable(ex_write_enable),
        .ex_pc_to_reg(ex_pc_to_reg), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .is_halted(is_halted)
    );

    // Downstream MEM stage: whatever sat in EX moves on one cycle later.
    always @(posedge clk) begin
        mem_rd           <= ex_rd;
        mem_write_enable <= ex_write_enable;
    end

    typedef struct packed {
        logic            v;
        logic [5:0]      ctl;
        logic [XLEN-1:0] pc, a, b, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      funct;
    } exrec_t;

    // {mem_read, mem_to_reg, mem_write, alu_src, write_enable, pc_to_reg, is_ecall}
    localparam logic [6:0] C_R  = 7'b0000100;
    localparam logic [6:0] C_I  = 7'b0001100;
    localparam logic [6:0] C_LW = 7'b1101100;
    localparam logic [6:0] C_SW = 7'b0011000;
    localparam logic [6:0] C_J  = 7'b0000110;
    localparam logic [6:0] C_EC = 7'b0000001;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] JAL_X1 = 32'h0005_00EF;  // rs1 field bits happen to read 10

    exrec_t    exp_q[$];
    int        checks = 0;
    int        failures = 0;
    logic [31:0] pc_ctr = 32'h100;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    task automatic set_id(input logic v, input logic [31:0] inst, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [6:0] ctl);
        id_valid    = v;
        id_inst     = inst;
        id_pc       = pc_ctr;
        id_rs1_data = a;
        id_rs2_data = b;
        id_imm      = imm;
        id_ctl      = ctl;
        pc_ctr      = pc_ctr + 32'd4;
    endtask

    task automatic cyc(input string tag, input bit exp_stall, input bit exp_bubble, input bit exp_halt);
        exrec_t e;
        exrec_t o;
        #1;
        check({tag, ":stall"}, 160'(stall), 160'(exp_stall));
        e = '0;
        if (!exp_bubble) begin
            e.v     = id_valid;
            e.ctl   = id_valid ? id_ctl[6:1] : 6'b0;
            e.pc    = id_pc;
            e.a     = id_rs1_data;
            e.b     = id_rs2_data;
            e.imm   = id_imm;
            e.rs1   = id_ctl[0] ? 5'd17 : id_inst[19:15];
            e.rs2   = id_inst[24:20];
            e.rd    = id_inst[11:7];
            e.funct = {id_inst[30], id_inst[14:12]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = {ex_valid, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_write_enable,
             ex_pc_to_reg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};
        e = exp_q.pop_front();
        check({tag, ":ex"}, 160'(o), 160'(e));
        check({tag, ":halt"}, 160'(is_halted), 160'(exp_halt));
    endtask

    task automatic ecall_to_issue(input string tag);
        set_id(1'b1, i_type(12'd10, 5'd0, 3'b000, 5'd17, 7'b0010011), 32'd0, 32'd0, 32'd10, C_I);
        cyc({tag, "_addi17"}, 0, 0, 0);
        set_id(1'b1, ECALL, 32'd10, 32'd0, 32'd0, C_EC);
`ifdef ECALL_STALL_EN
        cyc({tag, "_haz_ex"}, 1, 1, 0);
        cyc({tag, "_haz_mem"}, 1, 1, 0);
`endif
        cyc({tag, "_issue"}, 0, 1, 0);
    endtask

    initial begin
        reset = 1'b1;
        set_id(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h11, 32'h22, 32'h0, C_R);
        cyc("rst0", 0, 1, 0);
        cyc("rst1", 0, 1, 0);
        reset = 1'b0;
        cyc("add_first", 0, 0, 0);

        set_id(1'b1, i_type(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 32'h1000, 32'h0, 32'h0, C_LW);
        cyc("lw_x5", 0, 0, 0);
        set_id(1'b1, r_type(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 32'hAA, 32'hBB, 32'h0, C_R);
        cyc("lu_stall", 1, 1, 0);
        cyc("lu_issue", 0, 0, 0);

        set_id(1'b1, i_type(12'd4, 5'd2, 3'b010, 5'd0, 7'b0000011), 32'h2000, 32'h0, 32'h4, C_LW);
        cyc("lw_x0", 0, 0, 0);
        set_id(1'b1, r_type(7'h00, 5'd4, 5'd0, 3'b000, 5'd7), 32'h0, 32'h44, 32'h0, C_R);
        cyc("x0_use", 0, 0, 0);

        set_id(1'b1, i_type(12'd0, 5'd2, 3'b010, 5'd9, 7'b0000011), 32'h3000, 32'h0, 32'h0, C_LW);
        cyc("lw_x9", 0, 0, 0);
        set_id(1'b1, s_type(12'd8, 5'd9, 5'd3), 32'h30, 32'h99, 32'h8, C_SW);
        cyc("st_stall", 1, 1, 0);
        cyc("st_issue", 0, 0, 0);

        set_id(1'b1, i_type(12'd0, 5'd2, 3'b010, 5'd10, 7'b0000011), 32'h4000, 32'h0, 32'h0, C_LW);
        cyc("lw_x10", 0, 0, 0);
        set_id(1'b1, JAL_X1, 32'h0, 32'h0, 32'h40, C_J);
        cyc("jal_no_rs1", 0, 0, 0);

        set_id(1'b1, i_type(12'd0, 5'd2, 3'b010, 5'd11, 7'b0000011), 32'h5000, 32'h0, 32'h0, C_LW);
        cyc("lw_x11", 0, 0, 0);
        set_id(1'b0, r_type(7'h20, 5'd11, 5'd11, 3'b000, 5'd12), 32'h5, 32'h6, 32'h0, C_R);
        cyc("invalid_id", 0, 0, 0);
        set_id(1'b1, r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd12), 32'h7, 32'h3, 32'h0, C_R);
        cyc("sub", 0, 0, 0);

        set_id(1'b1, ECALL, 32'd5, 32'd0, 32'd0, C_EC);
        cyc("ecall_nop", 0, 0, 0);
        set_id(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd13), 32'h8, 32'h9, 32'h0, C_R);
        cyc("after_nop0", 0, 0, 0);
        cyc("after_nop1", 0, 0, 0);
        cyc("after_nop2", 0, 0, 0);

        ecall_to_issue("h1");
        set_id(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 32'h1, 32'h2, 32'h0, C_R);
        cyc("drain1", 0, 1, 0);
        cyc("drain2", 0, 1, 0);
        cyc("drain3", 0, 1, 1);
        cyc("halted", 0, 1, 1);

        reset = 1'b1;
        cyc("rst_halted", 0, 1, 0);
        reset = 1'b0;

        ecall_to_issue("h2");
        set_id(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd15), 32'h3, 32'h4, 32'h0, C_R);
        cyc("drain_a", 0, 1, 0);
        reset = 1'b1;
        cyc("rst_drain", 0, 1, 0);
        reset = 1'b0;
        cyc("run_again0", 0, 0, 0);
        cyc("run_again1", 0, 0, 0);
        cyc("run_again2", 0, 0, 0);
        cyc("run_again3", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the pipelined RV32I core. Sits directly downstream of the decode control unit. Registers its control bits together with operands, immediate, PC and register indices into the ID/EX pipeline register. Also detects load-use and ecall operand hazards, inserts bubbles, and runs the ecall halt-drain sequence that raises `is_halted` once older instructions retire.

## Interface
- `XLEN`, 32, datapath width
- `DRAIN_CYCLES`, 3, cycles from ecall issue to halt (EX, MEM, WB)
- `clk` in 1 clock; all state changes on rising edge
- `reset` in 1 synchronous, active-high reset
- `id_valid` in 1 IF/ID holds a real instruction
- `id_inst` in 32 instruction in ID
- `id_pc` in XLEN PC of ID instruction
- `id_rs1_data`, `id_rs2_data` in XLEN register-file read data (already WB-bypassed)
- `id_imm` in XLEN immediate
- `ctrl_mem_read`, `ctrl_mem_to_reg`, `ctrl_mem_write`, `ctrl_alu_src`, `ctrl_write_enable`, `ctrl_pc_to_reg`, `ctrl_is_ecall` in 1 each, decode control bits
- `mem_rd` in 5 destination of instruction in MEM
- `mem_write_enable` in 1 MEM instruction writes a register
- `stall` out 1 hold PC and IF/ID (combinational)
- `ex_valid` out 1 EX slot holds a real instruction
- `ex_mem_read`, `ex_mem_to_reg`, `ex_mem_write`, `ex_alu_src`, `ex_write_enable`, `ex_pc_to_reg` out 1 each, registered control
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm` out XLEN registered data
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5 registered indices (for forwarding unit)
- `ex_funct` out 4 {inst[30], inst[14:12]}
- `is_halted` out 1 core halted

## Operation
- rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7]; for ecall, rs1 is forced to 17.
- Uses rs1: every opcode except JAL/LUI/AUIPC. Uses rs2: ARITHMETIC, STORE, BRANCH.
- Load-use hazard: `ex_valid & ex_mem_read & ex_rd!=0 & ((ex_rd==rs1 & use_rs1) | (ex_rd==rs2 & use_rs2))`.
- Ecall hazard (macro-gated): ID is ecall and x17 is in flight. In flight means `ex_write_enable & ex_rd==17`, or `mem_write_enable & mem_rd==17`.
- `stall` = `id_valid` & (load-use | ecall hazard) & state==RUN.
- Per edge in RUN:
  - Stall: a bubble is loaded. All ex control bits and `ex_valid` are 0; data fields are don't-care and are zeroed.
  - Otherwise: ID fields are loaded, with `ex_valid = id_valid`. An invalid ID also zeroes control.
- FSM RUN → DRAIN: an unstalled valid ecall issues with `id_rs1_data==10`. The counter loads `DRAIN_CYCLES-1`. The ecall itself enters EX as a bubble, with no side effects.
- Ecall with x17≠10: treated as a NOP, state stays RUN.
- DRAIN: bubbles are loaded every cycle and `stall`=0. The upstream is squashed by the top level using `is_halted` / state. The counter decrements each cycle. At 0 → HALTED.
- HALTED: terminal until reset. Bubbles only; `is_halted`=1.

## Timing
- Reset values:
  - All `ex_*` outputs 0 and `ex_valid`=0.
  - State RUN, counter 0, `is_halted`=0.
  - `stall`=0.
- Latency: one cycle, ID to EX outputs.
- `stall` is combinational within the cycle. The bubble appears on EX outputs the next cycle. ID is re-evaluated the following cycle.
- Load-use costs exactly one bubble, because the load has moved to MEM next cycle.
- Ecall hazard costs at most 2 bubbles.
- `is_halted` rises exactly `DRAIN_CYCLES` edges after the ecall's issue edge.
- Reset takes priority over stall and over DRAIN/HALTED. Reset mid-drain returns to RUN with cleared counter.
- Load-use and ecall hazard together produce a single stall, with no double counting.
- rd==0 never causes a hazard.

## Configuration
- `ECALL_STALL_EN` defined: the ecall hazard term is active as above.
- `ECALL_STALL_EN` undefined: the ecall hazard term is 0. `id_rs1_data` is used as-is, and the top level must supply ID-stage forwarding of x17. Load-use detection is unaffected.

## Structure
- Shared package/header `pipeline_defs`:
  - FSM state encoding RUN/DRAIN/HALTED.
  - `DRAIN_CYCLES` default.
  - Register index constant for x17 and halt code 10.
  - Opcode constants come from the existing opcode header.
- Sub-module `hazard_detect` (combinational) takes the ID indices and use-flags plus the EX/MEM rd/write info. It returns `load_use` and `ecall_hazard`. The parent holds the pipeline register and FSM.

## Test plan
- Reset held 2 cycles with a valid ADD on inputs → all `ex_*`=0, `stall`=0, `is_halted`=0. First post-reset edge loads the ADD.
- `lw x5` in EX, `add x6,x5,x1` in ID → `stall`=1 for one cycle, EX shows bubble (`ex_write_enable`=0). Next cycle the ADD is issued with `ex_rs1`=5.
- `lw x0` in EX, consumer of x0 in ID → no stall.
- `addi x17,x0,10` in EX, ecall in ID (macro on) → 2 stall cycles. Then ecall issues, and `is_halted`=1 exactly 3 cycles later.
- Ecall with `id_rs1_data`=5 → no drain, state RUN, following instruction issues normally.
- Reset asserted during DRAIN (counter=1) → RUN next cycle, `is_halted` stays 0.
